// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: debounces MODE/INC buttons, walks the user
// through hour then minute entry, and commits the edited time with a one-cycle set strobe.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int BLINK_CYCLES    = 250000,
  parameter int MAX_HOURS       = 23,
  parameter int MAX_MINUTES     = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [6:0] cur_minutes,
  output logic       set,
  output logic [4:0] set_hours,
  output logic [6:0] set_minutes,
  output logic [1:0] edit_mode,
  output logic       blink
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  // Encodings 0..2 match the edit_mode values; COMMIT reports as RUN.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      raw, sync1, sync2, level, press;
  logic [DW-1:0]   db_cnt [2];
  logic [TW-1:0]   tmo_cnt;
  logic [BW-1:0]   blink_cnt;
  logic [4:0]      hr_q;
  logic [6:0]      min_q;
  logic            mode_ev, inc_ev, any_ev, timed_out, editing_q, editing_d;

  // Bit 0 is MODE, bit 1 is INC.
  assign raw     = {btn_inc, btn_mode};
  assign mode_ev = press[0];
  assign inc_ev  = press[1];
  assign any_ev  = mode_ev | inc_ev;

  // Synchronise, then accept a new level only after DEBOUNCE_CYCLES differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            level[i]  <= sync2[i];
            press[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign editing_q = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);
  assign editing_d = (state_d == ST_SET_HR) || (state_d == ST_SET_MIN);
  assign timed_out = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // MODE has priority over INC; a press in the same cycle as the timeout keeps the edit alive.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (mode_ev) state_d = ST_SET_HR;
      ST_SET_HR:  if (mode_ev) state_d = ST_SET_MIN;
                  else if (!any_ev && timed_out) state_d = ST_RUN;
      ST_SET_MIN: if (mode_ev) state_d = ST_COMMIT;
                  else if (!any_ev && timed_out) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hr_q  <= '0;
      min_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: if (mode_ev) begin
          hr_q  <= (cur_hours > 5'(MAX_HOURS)) ? 5'd0 : cur_hours;
          min_q <= (cur_minutes > 7'(MAX_MINUTES)) ? 7'd0 : cur_minutes;
        end
        ST_SET_HR: if (!mode_ev && inc_ev)
          hr_q <= (hr_q == 5'(MAX_HOURS)) ? 5'd0 : hr_q + 5'd1;
        ST_SET_MIN: if (!mode_ev && inc_ev)
          min_q <= (min_q == 7'(MAX_MINUTES)) ? 7'd0 : min_q + 7'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (any_ev || !editing_q) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Blink restarts high on every entry into an edit field.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (!editing_d) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (state_d != state_q) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set       <= 1'b0;
      edit_mode <= 2'd0;
    end else begin
      set       <= (state_d == ST_COMMIT);
      edit_mode <= (state_d == ST_COMMIT) ? 2'd0 : state_d;
    end
  end

  assign set_hours   = hr_q;
  assign set_minutes = min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences with a commit scoreboard
// checked by an independent monitor on the falling clock edge.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc;
  logic [4:0] cur_hours;
  logic [6:0] cur_minutes;
  logic       set;
  logic [4:0] set_hours;
  logic [6:0] set_minutes;
  logic [1:0] edit_mode;
  logic       blink;

  int          checks = 0;
  int          errors = 0;
  int          hr_entries = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_item;
  logic        set_prev = 1'b0;
  logic [1:0]  em_prev = 2'd0;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES(200),
    .BLINK_CYCLES(10),
    .MAX_HOURS(23),
    .MAX_MINUTES(59)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .set(set),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .edit_mode(edit_mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every set pulse must match the next queued commit and never repeat.
  always @(negedge clk) begin
    if (set) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL set_unexpected actual %0d:%0d required no set", set_hours, set_minutes);
      end else begin
        exp_item = exp_q.pop_front();
        if ({set_hours, set_minutes} !== exp_item) begin
          errors++;
          $display("FAIL set_value actual %0d:%0d required %0d:%0d",
                   set_hours, set_minutes, exp_item[11:7], exp_item[6:0]);
        end
      end
      checks++;
      if (set_prev) begin
        errors++;
        $display("FAIL set_double actual 2 cycles required 1 cycle");
      end
    end
    set_prev = set;
    if (em_prev == 2'd0 && edit_mode == 2'd1) hr_entries++;
    em_prev = edit_mode;
  end

  // Clean press: 10 cycles high then 10 low, long enough for the 4-sample debouncer.
  task automatic press(input bit is_mode);
    if (is_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    if (is_mode) btn_mode = 1'b0; else btn_inc = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic wait_mode(input logic [1:0] v, input int budget, input string name);
    int n;
    n = 0;
    while (edit_mode !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(edit_mode), 32'(v));
  endtask

  initial begin
    int base, n;
    logic b0;
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hours = 5'd0; cur_minutes = 7'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({set, set_hours, set_minutes, edit_mode, blink}), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Idle after reset, then INC alone must not start an edit.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({set, set_hours, set_minutes, edit_mode, blink}), 32'd0);
    end
    press(1'b0); press(1'b0);
    check("inc_in_run_mode", 32'(edit_mode), 32'd0);

    // 12:30 -> 14:35
    cur_hours = 5'd12; cur_minutes = 7'd30;
    press(1'b1);
    check("enter_set_hr", 32'(edit_mode), 32'd1);
    check("preload_hours", 32'(set_hours), 32'd12);
    check("preload_minutes", 32'(set_minutes), 32'd30);
    press(1'b0); press(1'b0);
    check("hours_inc", 32'(set_hours), 32'd14);
    press(1'b1);
    check("enter_set_min", 32'(edit_mode), 32'd2);
    for (int i = 0; i < 5; i++) press(1'b0);
    check("minutes_inc", 32'(set_minutes), 32'd35);
    exp_q.push_back({5'd14, 7'd35});
    press(1'b1);
    check("commit_drained", 32'(exp_q.size()), 32'd0);
    check("back_to_run", 32'(edit_mode), 32'd0);

    // 23:59 -> 0:00 on both wraps
    cur_hours = 5'd23; cur_minutes = 7'd59;
    press(1'b1);
    check("preload_23", 32'(set_hours), 32'd23);
    press(1'b0);
    check("hours_wrap", 32'(set_hours), 32'd0);
    press(1'b1); press(1'b0);
    check("minutes_wrap", 32'(set_minutes), 32'd0);
    exp_q.push_back({5'd0, 7'd0});
    press(1'b1);
    check("wrap_commit_drained", 32'(exp_q.size()), 32'd0);

    // Glitch and bounce on MODE; out-of-range core time preloads 0.
    cur_hours = 5'd25; cur_minutes = 7'd70;
    base = hr_entries;
    btn_mode = 1'b1; repeat (3) @(posedge clk); #1 btn_mode = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("glitch_ignored", 32'(edit_mode), 32'd0);
    check("glitch_no_entry", 32'(hr_entries - base), 32'd0);
    for (int i = 0; i < 5; i++) begin
      btn_mode = 1'b1; repeat (2) @(posedge clk); #1;
      btn_mode = 1'b0; repeat (2) @(posedge clk); #1;
    end
    btn_mode = 1'b1; repeat (10) @(posedge clk); #1;
    btn_mode = 1'b0; repeat (10) @(posedge clk); #1;
    check("bounce_one_entry", 32'(hr_entries - base), 32'd1);
    check("bounce_set_hr", 32'(edit_mode), 32'd1);
    check("clamp_hours", 32'(set_hours), 32'd0);
    check("clamp_minutes", 32'(set_minutes), 32'd0);

    // Timeout: the INC press restarts the idle count.
    press(1'b0);
    check("hours_after_clamp", 32'(set_hours), 32'd1);
    repeat (150) @(posedge clk); #1;
    check("before_timeout", 32'(edit_mode), 32'd1);
    repeat (60) @(posedge clk); #1;
    check("timeout_abort", 32'(edit_mode), 32'd0);
    check("shadow_retained", 32'(set_hours), 32'd1);

    // Asynchronous reset in the middle of minute entry.
    cur_hours = 5'd3; cur_minutes = 7'd4;
    press(1'b1); press(1'b1);
    check("mid_set_min", 32'(edit_mode), 32'd2);
    @(posedge clk); #2 reset = 1'b0;
    #1 check("reset_async", 32'({set, set_hours, set_minutes, edit_mode, blink}), 32'd0);
    repeat (3) @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("after_reset_run", 32'(edit_mode), 32'd0);

    // Simultaneous MODE+INC in SET_HR, then blink timing in SET_MIN.
    cur_hours = 5'd5; cur_minutes = 7'd10;
    press(1'b1);
    check("enter_hr_5", 32'(edit_mode), 32'd1);
    btn_mode = 1'b1; btn_inc = 1'b1;
    wait_mode(2'd2, 30, "simul_to_set_min");
    check("simul_hours_kept", 32'(set_hours), 32'd5);
    check("blink_restart_high", 32'(blink), 32'd1);
    repeat (15) @(posedge clk); #1;
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    b0 = blink; n = 0;
    while (blink === b0 && n < 30) begin @(negedge clk); n++; end
    check("blink_toggle_seen", 32'(n < 30), 32'd1);
    for (int k = 0; k < 2; k++) begin
      b0 = blink; n = 0;
      while (blink === b0 && n < 30) begin @(negedge clk); n++; end
      check("blink_half_period", 32'(n), 32'd10);
    end
    exp_q.push_back({5'd5, 7'd10});
    @(posedge clk); #1;
    press(1'b1);
    check("simul_commit_drained", 32'(exp_q.size()), 32'd0);
    check("end_run", 32'(edit_mode), 32'd0);
    check("blink_run", 32'(blink), 32'd0);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
